// File: rtl/axi_pwm_ramp_seq.sv
// ============================================================================
// Module   : axi_pwm_ramp_seq
// Brief    : AXI4-Lite write-only master that programs an axi_pwm slave and
//            ramps its duty register from a start value to an end value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_pwm_ramp_seq #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       cfg_period,
    input  logic [31:0]       cfg_duty_start,
    input  logic [31:0]       cfg_duty_end,
    input  logic [15:0]       cfg_step,
    input  logic [23:0]       cfg_interval,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cur_duty,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_PERIOD = 3'd1,
        S_WR_EN     = 3'd2,
        S_WR_DUTY   = 3'd3,
        S_WAIT      = 3'd4,
        S_WR_DIS    = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    localparam logic [3:0] c_OFF_CTRL   = 4'h0;
    localparam logic [3:0] c_OFF_PERIOD = 4'h4;
    localparam logic [3:0] c_OFF_DUTY   = 4'h8;

    state_t r_state, w_next;

    logic              r_busy, r_done, r_err;
    logic [31:0]       r_cur_duty;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic              r_awvalid, r_wvalid, r_bready;
    logic              r_aw_done, r_w_done;
    logic [31:0]       r_duty, r_end;
    logic [15:0]       r_step;
    logic [23:0]       r_interval, r_cnt;
    logic              r_up;

    logic        w_launch, w_to_wait, w_duty_ok;
    logic [3:0]  w_off;
    logic [31:0] w_data;
    logic        w_aw_hs, w_w_hs, w_b_hs, w_in_wr;
    logic [32:0] w_d33, w_e33, w_s33, w_dist, w_stepped;
    logic [31:0] w_duty_nxt;

    assign w_aw_hs = r_awvalid & m_axi_awready;
    assign w_w_hs  = r_wvalid & m_axi_wready;
    assign w_b_hs  = r_bready & m_axi_bvalid;
    assign w_in_wr = (r_state == S_WR_PERIOD) || (r_state == S_WR_EN) ||
                     (r_state == S_WR_DUTY)   || (r_state == S_WR_DIS);

    // Clamp against the end value using the remaining distance, so neither
    // direction can overshoot or wrap.
    assign w_d33      = {1'b0, r_duty};
    assign w_e33      = {1'b0, r_end};
    assign w_s33      = {17'b0, r_step};
    assign w_dist     = r_up ? (w_e33 - w_d33) : (w_d33 - w_e33);
    assign w_stepped  = r_up ? (w_d33 + w_s33) : (w_d33 - w_s33);
    assign w_duty_nxt = (w_dist <= w_s33) ? r_end : w_stepped[31:0];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_off     = c_OFF_CTRL;
        w_data    = 32'h0;
        w_to_wait = 1'b0;
        w_duty_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_WR_PERIOD;
                    w_launch = 1'b1;
                    w_off    = c_OFF_PERIOD;
                    w_data   = cfg_period;
                end
            end
            S_WR_PERIOD, S_WR_EN, S_WR_DUTY, S_WR_DIS: begin
                if (w_b_hs) begin
                    if (m_axi_bresp != 2'b00 || r_state == S_WR_DIS) begin
                        w_next = S_FIN;
                    end else begin
                        w_duty_ok = (r_state == S_WR_DUTY);
                        if (abort) begin
                            w_next   = S_WR_DIS;
                            w_launch = 1'b1;
                        end else if (r_state == S_WR_PERIOD) begin
                            w_next   = S_WR_EN;
                            w_launch = 1'b1;
                            w_data   = 32'h1;
                        end else if (r_state == S_WR_EN) begin
                            w_next   = S_WR_DUTY;
                            w_launch = 1'b1;
                            w_off    = c_OFF_DUTY;
                            w_data   = r_duty;
                        end else if (r_duty == r_end) begin
                            w_next = S_FIN;
                        end else begin
                            w_next    = S_WAIT;
                            w_to_wait = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_next   = S_WR_DIS;
                    w_launch = 1'b1;
                end else if (r_cnt == 24'd0) begin
                    w_next   = S_WR_DUTY;
                    w_launch = 1'b1;
                    w_off    = c_OFF_DUTY;
                    w_data   = r_duty;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cur_duty <= 32'h0;
            r_awaddr   <= '0;
            r_wdata    <= 32'h0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_duty     <= 32'h0;
            r_end      <= 32'h0;
            r_step     <= 16'h0;
            r_interval <= 24'h0;
            r_cnt      <= 24'h0;
            r_up       <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_duty     <= cfg_duty_start;
                r_end      <= cfg_duty_end;
                r_step     <= (cfg_step == 16'h0) ? 16'h1 : cfg_step;
                r_interval <= cfg_interval;
                r_up       <= (cfg_duty_end >= cfg_duty_start);
                r_err      <= 1'b0;
                r_busy     <= 1'b1;
            end

            if (w_launch) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= BASE_ADDR + ADDR_W'(w_off);
                r_wdata   <= w_data;
            end else begin
                if (w_aw_hs) r_awvalid <= 1'b0;
                if (w_w_hs)  r_wvalid  <= 1'b0;
            end

            // The B channel opens only once both AW and W have been accepted.
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bready  <= 1'b0;
                if (m_axi_bresp != 2'b00) r_err <= 1'b1;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
                if (w_in_wr && !r_bready && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    r_bready <= 1'b1;
            end

            if (w_duty_ok) r_cur_duty <= r_duty;

            if (w_to_wait) begin
                r_duty <= w_duty_nxt;
                r_cnt  <= r_interval;
            end else if (r_state == S_WAIT && r_cnt != 24'd0) begin
                r_cnt <= r_cnt - 24'd1;
            end

            r_done <= (r_state != S_FIN) && (w_next == S_FIN);
            if (r_state == S_FIN) r_busy <= 1'b0;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign cur_duty      = r_cur_duty;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

endmodule

`default_nettype wire

// File: tb/tb_axi_pwm_ramp_seq.sv
// ============================================================================
// Module   : tb_axi_pwm_ramp_seq
// Brief    : Directed self-checking bench for axi_pwm_ramp_seq with a
//            configurable-latency AXI4-Lite write slave and transaction log.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_pwm_ramp_seq;

    logic        clk, rst;
    logic        start, abort;
    logic [31:0] cfg_period, cfg_duty_start, cfg_duty_end;
    logic [15:0] cfg_step;
    logic [23:0] cfg_interval;
    logic        busy, done, err;
    logic [31:0] cur_duty;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_pwm_ramp_seq #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .ACLK(clk), .ARESET(rst), .start(start), .abort(abort),
        .cfg_period(cfg_period), .cfg_duty_start(cfg_duty_start),
        .cfg_duty_end(cfg_duty_end), .cfg_step(cfg_step), .cfg_interval(cfg_interval),
        .busy(busy), .done(done), .err(err), .cur_duty(cur_duty),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, err_idx = -1;

    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    int          gap     [256];
    int n_wr = 0, aw_rises = 0, w_rises = 0, done_cnt = 0, b_viol = 0;
    int cyc = 0, last_b = 0;
    logic [31:0] cap_addr, cap_data;
    logic prev_aw = 1'b0, prev_w = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    // Slave: ready/valid responses with programmable latency, updated on negedge.
    initial begin : slave
        int aw_cnt, w_cnt, b_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            w_cnt   = wvalid  ? w_cnt + 1  : 0;
            b_cnt   = bready  ? b_cnt + 1  : 0;
            awready = awvalid && (aw_cnt > aw_dly);
            wready  = wvalid  && (w_cnt > w_dly);
            bvalid  = bready  && (b_cnt > b_dly);
            bresp   = (n_wr == err_idx) ? 2'b10 : 2'b00;
        end
    end

    // Transaction log: one entry per completed B handshake.
    always @(posedge clk) begin
        if (rst) begin
            aw_seen = 1'b0;
            w_seen  = 1'b0;
        end
        if (awvalid && awready) begin cap_addr = awaddr; aw_seen = 1'b1; end
        if (wvalid && wready)   begin cap_data = wdata;  w_seen  = 1'b1; end
        if (bready && !(aw_seen && w_seen)) b_viol++;
        if (bready && bvalid && n_wr < 256) begin
            wr_addr[n_wr] = cap_addr;
            wr_data[n_wr] = cap_data;
            n_wr++;
            last_b  = cyc;
            aw_seen = 1'b0;
            w_seen  = 1'b0;
        end
        if (awvalid && !prev_aw) begin
            aw_rises++;
            if (n_wr < 256) gap[n_wr] = cyc - 1 - last_b;
        end
        if (wvalid && !prev_w) w_rises++;
        if (done) done_cnt++;
        prev_aw = awvalid;
        prev_w  = wvalid;
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start(input logic [31:0] p, input logic [31:0] s, input logic [31:0] e,
                               input logic [15:0] st, input logic [23:0] iv);
        @(negedge clk);
        cfg_period = p; cfg_duty_start = s; cfg_duty_end = e;
        cfg_step = st; cfg_interval = iv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_seq(input string tag, input int base);
        chk({tag, "_nwr"}, 64'(n_wr - base), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), {wr_addr[base + i], wr_data[base + i]},
                {exp_a[i], exp_d[i]});
    endtask

    initial begin : main
        int base, d0, a0, w0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_period = 0; cfg_duty_start = 0; cfg_duty_end = 0; cfg_step = 0; cfg_interval = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {58'd0, busy, done, err, awvalid, wvalid, bready}, 64'd0);
        chk("rst_data", {cur_duty, wdata}, 64'd0);
        chk("rst_addr", 64'(awaddr), 64'd0);
        rst = 1'b0;

        // Up ramp
        exp_a = '{32'h4, 32'h0, 32'h8, 32'h8, 32'h8, 32'h8};
        exp_d = '{32'd1000, 32'd1, 32'd0, 32'd10, 32'd20, 32'd30};
        base = n_wr; d0 = done_cnt;
        pulse_start(32'd1000, 32'd0, 32'd30, 16'd10, 24'd4);
        chk("up_busy", 64'(busy), 64'd1);
        wait_done("up");
        check_seq("up", base);
        for (int i = 3; i < 6; i++) chk($sformatf("up_gap%0d", i), 64'(gap[base + i]), 64'd5);
        chk("up_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("up_cur", 64'(cur_duty), 64'd30);
        chk("up_idle", {62'd0, busy, err}, 64'd0);

        // Down ramp, clamped at end, zero interval
        exp_a = '{32'h4, 32'h0, 32'h8, 32'h8, 32'h8, 32'h8};
        exp_d = '{32'd500, 32'd1, 32'd25, 32'd15, 32'd5, 32'd0};
        base = n_wr;
        pulse_start(32'd500, 32'd25, 32'd0, 16'd10, 24'd0);
        wait_done("dn");
        check_seq("dn", base);
        chk("dn_gap", 64'(gap[base + 4]), 64'd1);
        chk("dn_err", 64'(err), 64'd0);
        chk("dn_cur", 64'(cur_duty), 64'd0);

        // Backpressure on AW and B
        aw_dly = 3; b_dly = 2;
        exp_a = '{32'h4, 32'h0, 32'h8, 32'h8, 32'h8, 32'h8};
        exp_d = '{32'd1000, 32'd1, 32'd0, 32'd10, 32'd20, 32'd30};
        base = n_wr; a0 = aw_rises; w0 = w_rises;
        pulse_start(32'd1000, 32'd0, 32'd30, 16'd10, 24'd4);
        wait_done("bp");
        check_seq("bp", base);
        chk("bp_aw_rises", 64'(aw_rises - a0), 64'd6);
        chk("bp_w_rises", 64'(w_rises - w0), 64'd6);
        chk("bp_bready_early", 64'(b_viol), 64'd0);
        aw_dly = 0; b_dly = 0;

        // SLVERR on the PERIOD write
        base = n_wr; d0 = done_cnt; err_idx = n_wr;
        pulse_start(32'd1000, 32'd0, 32'd30, 16'd10, 24'd4);
        wait_done("se");
        err_idx = -1;
        chk("se_err", 64'(err), 64'd1);
        chk("se_nwr", 64'(n_wr - base), 64'd1);
        chk("se_done_cnt", 64'(done_cnt - d0), 64'd1);
        repeat (5) @(negedge clk);
        chk("se_no_more", 64'(n_wr - base), 64'd1);

        // Abort during WAIT; start also clears sticky err
        base = n_wr;
        pulse_start(32'd1000, 32'd0, 32'd100, 16'd10, 24'd20);
        chk("ab_err_clr", 64'(err), 64'd0);
        for (int i = 0; i < 500 && n_wr < base + 4; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        wait_done("ab");
        abort = 1'b0;
        exp_a = '{32'h4, 32'h0, 32'h8, 32'h8, 32'h0};
        exp_d = '{32'd1000, 32'd1, 32'd0, 32'd10, 32'd0};
        check_seq("ab", base);
        chk("ab_cur", 64'(cur_duty), 64'd10);

        // start while busy is ignored
        base = n_wr;
        pulse_start(32'd1000, 32'd0, 32'd30, 16'd10, 24'd4);
        for (int i = 0; i < 200 && n_wr < base + 2; i++) @(negedge clk);
        pulse_start(32'd77, 32'd5, 32'd9, 16'd1, 24'd0);
        wait_done("sb");
        exp_a = '{32'h4, 32'h0, 32'h8, 32'h8, 32'h8, 32'h8};
        exp_d = '{32'd1000, 32'd1, 32'd0, 32'd10, 32'd20, 32'd30};
        check_seq("sb", base);

        // Reset while W is still pending
        w_dly = 5;
        pulse_start(32'd1000, 32'd0, 32'd30, 16'd10, 24'd4);
        repeat (2) @(negedge clk);
        chk("rw_pending", {62'd0, awvalid, wvalid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rw_ctl", {58'd0, busy, done, err, awvalid, wvalid, bready}, 64'd0);
        chk("rw_data", {awaddr, wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        w_dly = 0;
        repeat (2) @(negedge clk);
        base = n_wr;
        pulse_start(32'd1000, 32'd0, 32'd30, 16'd10, 24'd4);
        wait_done("rw");
        check_seq("rw", base);
        chk("rw_cur", 64'(cur_duty), 64'd30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_pwm_ramp_seq.md
Name: axi_pwm_ramp_seq

Overview:
- AXI4-Lite write-only master that configures and sequences one axi_pwm slave.
- On start it programs the PWM period, enables the PWM, then ramps the duty register from a start value to an end value.
- The ramp moves in fixed steps, with one duty update per programmable interval.
- Sits beside the PWM slave on the same AXI4-Lite interconnect port, replacing software-driven duty ramps.

Parameters:
- ADDR_W, 32, width of m_axi_awaddr.
- BASE_ADDR, 32'h0, base address of the PWM slave. Register offsets are fixed: CTRL=0x0, PERIOD=0x4, DUTY=0x8.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; samples the cfg_* inputs when idle.
- abort  in  1  level; requests early stop.
- cfg_period  in  32  value written to PERIOD.
- cfg_duty_start  in  32  first duty value.
- cfg_duty_end  in  32  final duty value.
- cfg_step  in  16  duty increment magnitude; 0 is treated as 1.
- cfg_interval  in  24  ACLK cycles from a duty write's BRESP to the next duty write.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at sequence end (normal, abort or error).
- err  out  1  sticky; set on non-OKAY BRESP; cleared by the next accepted start.
- cur_duty  out  32  last duty value acknowledged with OKAY.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.

Behaviour:
- Reset (async, ARESET=1): state IDLE; all outputs 0 (busy, done, err, cur_duty, awvalid, wvalid, bready, awaddr, wdata); internal counters 0.
- States: IDLE -> WR_PERIOD -> WR_EN -> WR_DUTY -> WAIT -> WR_DUTY ... -> WR_DIS (abort only) -> FIN -> IDLE.
- IDLE: start=1 latches cfg_*, clears err, sets busy, enters WR_PERIOD. start while busy is ignored.
- Write transaction, common to every WR_* state:
  - Cycle after entry: awvalid and wvalid both 1, with awaddr=BASE_ADDR+offset and wdata=value.
  - awvalid drops the cycle after awready&awvalid; wvalid drops the cycle after wready&wvalid. The two channels complete independently, in either order or the same cycle.
  - Neither valid is re-asserted for the same write.
  - Once both have completed, bready=1 until bvalid; bready drops the cycle after the B handshake.
  - Valids never drop before their handshake. abort does not cancel a transaction in flight.
- Write values:
  - WR_PERIOD: PERIOD=cfg_period.
  - WR_EN: CTRL=1.
  - WR_DUTY: DUTY=d. The first d is cfg_duty_start.
  - WR_DIS: CTRL=0.
- After an OKAY B in WR_DUTY:
  - cur_duty<=d.
  - If d==cfg_duty_end go to FIN; else go to WAIT.
- WAIT:
  - Counts cfg_interval cycles; cfg_interval=0 means WR_DUTY is entered the next cycle.
  - Next d is computed with 33-bit arithmetic:
    - up ramp (end>=start): d=min(d+step, end)
    - down ramp: d=max(d-step, end); no underflow below end.
- Non-OKAY bresp in any state: err<=1, then FIN. No further writes, including no disable write.
- abort=1 sampled at any point after the B of the current write (or in WAIT): go to WR_DIS, then FIN. abort in WR_DIS is ignored.
- FIN: done=1 for one cycle, busy<=0, then IDLE.
- cfg_duty_start==cfg_duty_end: exactly one duty write, then FIN.
- Reset mid-transaction drops valids immediately; the slave must share the reset.

Test Plan:
- Up ramp: period=1000, start=0, end=30, step=10, interval=4.
  - Required: write sequence 0x4=1000, 0x0=1, 0x8=0,10,20,30.
  - Gap from each DUTY BRESP to the next awvalid = 5 cycles.
  - done pulses once; cur_duty=30.
- Down ramp with clamp: start=25, end=0, step=10, interval=0.
  - Required: DUTY writes 25,15,5,0; no value below 0; err=0.
- Backpressure: awready delayed 3 cycles, wready immediate, bvalid delayed 2 cycles on every write.
  - Required: same write sequence; each valid asserted exactly once per write; bready only after both channels complete.
- SLVERR: bresp=2'b10 on the PERIOD write.
  - Required: err=1, done pulses, no CTRL or DUTY write issued.
  - A later start clears err.
- Abort during WAIT after DUTY=10 (ramp 0->100).
  - Required: next write is 0x0=0, then done; cur_duty=10.
- start pulsed while busy: ignored, sequence unchanged.
  - ARESET asserted mid-W handshake: all outputs 0 the same cycle; a new start after release runs a full sequence.
